// File: rtl/zircon_led_pkg.sv
// zircon_led_pkg: shared state encoding and default sizing for the LED shift-register driver.
package zircon_led_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_PWM_W   = 8;
endpackage

// File: rtl/zircon_led_pwm.sv
// zircon_led_pwm: free-running PWM counter and compare giving the LED output-enable window.
module zircon_led_pwm #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] brightness,
    output logic             on
);
    logic [PWM_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_q + PWM_W'(1);
    assign on = cnt_q < brightness;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/zircon_led_shifter.sv
// zircon_led_shifter: serialises the LED word MSB-first into a 74HC595 chain and drives its latch/OE.
// Define ZIRCON_LED_PWM_EN to dim the chain through ser_oe_n using the brightness input.
module zircon_led_shifter
    import zircon_led_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int PWM_W   = DEF_PWM_W
) (
    input  logic              csi_clk,
    input  logic              rsi_reset,
    input  logic [DATA_W-1:0] led_data,
    input  logic [PWM_W-1:0]  brightness,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_latch,
    output logic              ser_oe_n,
    output logic              busy,
    output logic              frame_done
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = DATA_W > 1 ? $clog2(DATA_W) : 1;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shadow_q, shadow_d;
    logic              sent_once_q, sent_once_d;
    logic              ser_data_q, ser_data_d, ser_clk_q, ser_clk_d;
    logic              ser_latch_q, ser_latch_d, oe_n_q, oe_n_d, frame_done_q, frame_done_d;
    logic              tick, pending, oe_on;

    assign tick    = div_q == DIV_W'(CLK_DIV - 1);
    assign pending = (led_data != shadow_q) || !sent_once_q;

`ifdef ZIRCON_LED_PWM_EN
    zircon_led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk        (csi_clk),
        .rst        (rsi_reset),
        .brightness (brightness),
        .on         (oe_on)
    );
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign oe_on = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        div_d        = div_q + DIV_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        shadow_d     = shadow_q;
        sent_once_d  = sent_once_q;
        ser_data_d   = ser_data_q;
        ser_clk_d    = ser_clk_q;
        ser_latch_d  = ser_latch_q;
        frame_done_d = 1'b0;
        // Enable is held off until the chain has been loaded at least once.
        oe_n_d       = !(sent_once_q && oe_on);
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (pending) begin
                    shift_d    = led_data;
                    shadow_d   = led_data;
                    ser_data_d = led_data[DATA_W-1];
                    bit_cnt_d  = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: if (tick) begin
                div_d     = '0;
                ser_clk_d = 1'b1;
                state_d   = HIGH;
            end
            HIGH: if (tick) begin
                div_d     = '0;
                ser_clk_d = 1'b0;
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    ser_latch_d = 1'b1;
                    state_d     = LATCH;
                end else begin
                    shift_d    = shift_q << 1;
                    ser_data_d = shift_q[DATA_W-2];
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    state_d    = SETUP;
                end
            end
            LATCH: if (tick) begin
                div_d        = '0;
                ser_latch_d  = 1'b0;
                sent_once_d  = 1'b1;
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            shadow_q     <= '0;
            sent_once_q  <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_clk_q    <= 1'b0;
            ser_latch_q  <= 1'b0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            shadow_q     <= shadow_d;
            sent_once_q  <= sent_once_d;
            ser_data_q   <= ser_data_d;
            ser_clk_q    <= ser_clk_d;
            ser_latch_q  <= ser_latch_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_data   = ser_data_q;
    assign ser_clk    = ser_clk_q;
    assign ser_latch  = ser_latch_q;
    assign ser_oe_n   = oe_n_q;
    assign busy       = state_q != IDLE;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_zircon_led_shifter.sv
// tb_zircon_led_shifter: scoreboard bench decoding the serial stream back into LED words.
module tb_zircon_led_shifter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led_data = 8'h00;
    logic [7:0] brightness = 8'd64;
    logic       ser_data, ser_clk, ser_latch, ser_oe_n, busy, frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    zircon_led_shifter dut (
        .csi_clk    (clk),
        .rsi_reset  (rst),
        .led_data   (led_data),
        .brightness (brightness),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .ser_oe_n   (ser_oe_n),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: rebuilds each shifted word and scores it when the latch rises.
    logic       prev_clk = 1'b0, prev_lat = 1'b0;
    logic [7:0] word = '0;
    int         nbits = 0, lat_len = 0;
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
            lat_len = 0;
            prev_clk = 1'b0;
            prev_lat = 1'b0;
        end else begin
            if (ser_clk && !prev_clk) begin
                word = {word[6:0], ser_data};
                nbits++;
            end
            if (ser_latch && !prev_lat) begin
                chk("bits_per_frame", nbits, 8);
                if (exp_q.size() == 0) chk("sb_underrun", 32'(word), 32'hFFFF);
                else chk("frame_word", 32'(word), 32'(exp_q.pop_front()));
                nbits = 0;
            end
            if (ser_latch) lat_len++;
            if (!ser_latch && prev_lat) begin
                chk("latch_len", lat_len, 4);
                lat_len = 0;
            end
            prev_clk = ser_clk;
            prev_lat = ser_latch;
        end
    end

    task automatic wait_done(output int n, output int b);
        n = 0;
        b = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy) b++;
        end while (!frame_done && n < 400);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_data"}, ser_data, 0);
        chk({tag, "_clk"}, ser_clk, 0);
        chk({tag, "_latch"}, ser_latch, 0);
        chk({tag, "_oe_n"}, ser_oe_n, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    initial begin
        int n, b, act, k;
        repeat (3) @(negedge clk);
        #1 chk_reset_outs("rst");
        exp_q.push_back(8'h00);
        @(negedge clk) rst = 1'b0;
        wait_done(n, b);
        chk("f0_len", n, 69);
        chk("f0_busy", b, 68);
        chk("f0_oe_pre", ser_oe_n, 1);
        @(posedge clk); #1;
        chk("f0_oe_post", ser_oe_n, 0);

        led_data = 8'hA5;
        exp_q.push_back(8'hA5);
        wait_done(n, b);
        chk("a5_len", n, 69);
        chk("a5_busy", b, 68);

        led_data = 8'h0F;
        exp_q.push_back(8'h0F);
        repeat (10) @(posedge clk);
        #1 led_data = 8'hF0;
        repeat (20) @(posedge clk);
        #1 led_data = 8'h3C;
        exp_q.push_back(8'h3C);
        wait_done(n, b);
        wait_done(n, b);
        chk("back2back_len", n, 69);

        act = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (ser_clk || ser_latch || busy) act++;
        end
        chk("idle_activity", act, 0);

        led_data = 8'h5A;
        exp_q.push_back(8'h5A);
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (nbits < 4 && k < 200);
        chk("bit4_reached", nbits, 4);
        rst = 1'b1;
        #1 chk_reset_outs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(n, b);
        chk("postrst_len", n, 69);
        repeat (3) @(posedge clk);

`ifdef ZIRCON_LED_PWM_EN
        act = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (!ser_oe_n) act++;
        end
        chk("pwm64_on", act, 64);
        brightness = 8'd0;
        repeat (3) @(posedge clk);
        act = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (!ser_oe_n) act++;
        end
        chk("pwm0_on", act, 0);
`else
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!ser_oe_n) act++;
        end
        chk("oe_on", act, 300);
`endif
        chk("sb_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zircon_led_shifter.md
Name: zircon_led_shifter

Overview:
- Downstream stage of the Avalon-MM LED peripheral: consumes its 8-bit parallel `coe_led` output.
- Serialises that data MSB-first into an external 74HC595-style shift/latch chain on the POV board.
- Optionally dims the LEDs through the chip's active-low output enable using PWM.
- Sits between the Qsys LED peripheral and the FPGA pins.

Parameters:
- DATA_W, 8, width of parallel LED word and number of bits shifted per frame.
- CLK_DIV, 4, csi_clk cycles per serial half-period (>=1).
- PWM_W, 8, brightness/PWM counter width.

Ports:
- csi_clk  input  1  system clock
- rsi_reset  input  1  asynchronous active-high reset
- led_data  input  DATA_W  parallel LED word from the LED peripheral's `coe_led`
- brightness  input  PWM_W  duty value; used only when the PWM feature is built in
- ser_data  output  1  serial data to shift-register chain
- ser_clk  output  1  shift clock (SRCLK); data is sampled on its rising edge
- ser_latch  output  1  storage-register latch (RCLK)
- ser_oe_n  output  1  active-low output enable of shift-register chain
- busy  output  1  high while a frame is in progress (any state except IDLE)
- frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- One clock domain, csi_clk. Reset is asynchronous and active-high on `rsi_reset`.
- Reset values:
  - Outputs: ser_data=0, ser_clk=0, ser_latch=0, ser_oe_n=1, busy=0, frame_done=0.
  - Internals: shadow=0, sent_once=0, state=IDLE.
- Pending condition: `(led_data != shadow) || !sent_once`. It is evaluated only in IDLE.
- IDLE, pending:
  - Capture shift_reg<=led_data and shadow<=led_data.
  - Drive ser_data<=led_data[DATA_W-1]; clear bit_cnt and the divider.
  - Go to SETUP.
- IDLE, not pending: stay in IDLE.
- Divider tick = CLK_DIV cycles since the divider was last cleared. The divider clears on every state entry.
- SETUP: ser_clk=0 for one tick, then go to HIGH.
- HIGH: ser_clk=1 for one tick. At tick end:
  - If bit_cnt==DATA_W-1, go to LATCH.
  - Otherwise shift_reg shifts left, ser_data takes the next bit, bit_cnt increments, go to SETUP.
- LATCH: ser_clk=0 and ser_latch=1 for one tick. At tick end:
  - ser_latch=0, sent_once=1.
  - frame_done pulses in the cycle the state returns to IDLE.
- Frame length: (2*DATA_W+1)*CLK_DIV cycles after the capture cycle. With defaults this is 68 cycles.
- Minimum IDLE dwell is one cycle between frames.
- led_data changes during a frame are ignored for that frame. They are re-compared in IDLE, so the latest value is always sent next. Intermediate values may be skipped.
- ser_data is stable for a full tick before and during each ser_clk high phase.
- Reset mid-frame:
  - All outputs return to reset values immediately.
  - Because sent_once clears, a fresh frame starts the first cycle after reset deasserts.
- CLK_DIV=1: each state lasts exactly one cycle.

Optional Feature:
- Macro: ZIRCON_LED_PWM_EN.
- With the macro defined:
  - A free-running PWM_W-bit counter wraps from 2^PWM_W-1 to 0.
  - ser_oe_n = !(sent_once && (pwm_cnt < brightness)), registered with one cycle latency.
  - brightness=0 means always off.
  - brightness=255 means on 255 of every 256 cycles.
- Without the macro:
  - ser_oe_n = !sent_once, registered.
  - The brightness port is ignored.
- In both builds, ser_oe_n stays 1 until the first latch completes, so no garbage appears at power-up.

Decomposition:
- Package zircon_led_pkg holds:
  - the state enum {IDLE, SETUP, HIGH, LATCH};
  - default DATA_W, CLK_DIV and PWM_W constants.
- One sub-module, zircon_led_pwm: counter plus compare, producing the on/off enable. It is instantiated only under ZIRCON_LED_PWM_EN.

Test Plan:
- Release reset with led_data=8'h00 -> one frame starts despite equal shadow; 8 ser_clk rising edges all with ser_data=0; ser_latch high 4 cycles; frame_done pulse at cycle 69; ser_oe_n falls after the latch.
- led_data=8'hA5 in IDLE -> bits on successive ser_clk rises are 1,0,1,0,0,1,0,1; busy high for exactly 68 cycles after capture.
- Change led_data 8'h0F->8'hF0->8'h3C mid-frame -> current frame completes with 8'h0F; next frame sends 8'h3C; 8'hF0 is never sent.
- Hold led_data constant after a frame -> no further ser_clk or ser_latch activity for 1000 cycles; busy stays 0.
- Assert rsi_reset at bit 4 of a frame -> all outputs go to reset values the same cycle; after release, a full frame of the current led_data is sent.
- With ZIRCON_LED_PWM_EN and brightness=64 -> ser_oe_n low for 64 of every 256 cycles. Under brightness=0, ser_oe_n is constantly 1. Without the macro, ser_oe_n is constantly 0 after the first frame.
